// File: rtl/regfile_wb_arbiter.sv
//============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin ALU/MEM writeback arbiter onto the register-file
//            write port, with a pending-write scoreboard for the issue stage.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_iss_valid,
  input  logic [AW-1:0] i_iss_rd,
  output logic          o_iss_ready,
  input  logic [AW-1:0] i_q_addr1,
  input  logic [AW-1:0] i_q_addr2,
  output logic          o_q_busy1,
  output logic          o_q_busy2,
  input  logic          i_alu_valid,
  input  logic [AW-1:0] i_alu_rd,
  input  logic [DW-1:0] i_alu_data,
  output logic          o_alu_ready,
  input  logic          i_mem_valid,
  input  logic [AW-1:0] i_mem_rd,
  input  logic [DW-1:0] i_mem_data,
  output logic          o_mem_ready,
  output logic          o_rf_wr,
  output logic [AW-1:0] o_rf_addr,
  output logic [DW-1:0] o_rf_data,
  output logic [AW:0]   o_pend_cnt
);

  logic [NREG-1:0] r_pending;
  logic            r_rr_last;
  logic            r_rf_wr;
  logic [AW-1:0]   r_rf_addr;
  logic [DW-1:0]   r_rf_data;
  logic [AW:0]     r_pend_cnt;

  logic            w_iss_ready;
  logic            w_iss_fire;
  logic            w_gnt_mem;
  logic            w_gnt_alu;
  logic            w_grant;
  logic [AW-1:0]   w_gnt_rd;
  logic [DW-1:0]   w_gnt_data;
  logic [NREG-1:0] w_pend_nxt;
  logic [AW:0]     w_cnt_nxt;

  // Readiness looks only at the registered scoreboard, never at this cycle's grant.
  assign w_iss_ready = !i_iss_valid || (i_iss_rd == '0) || !r_pending[i_iss_rd];
  assign w_iss_fire  = i_iss_valid && w_iss_ready && (i_iss_rd != '0);

  // MEM wins a contested cycle unless it was the most recent winner.
  assign w_gnt_mem  = i_mem_valid && (!i_alu_valid || !r_rr_last);
  assign w_gnt_alu  = i_alu_valid && !w_gnt_mem;
  assign w_grant    = w_gnt_mem || w_gnt_alu;
  assign w_gnt_rd   = w_gnt_mem ? i_mem_rd   : i_alu_rd;
  assign w_gnt_data = w_gnt_mem ? i_mem_data : i_alu_data;

  // Clear first, then set, so a same-register issue overrides a stale writeback.
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_grant) begin
      w_pend_nxt[w_gnt_rd] = 1'b0;
    end
    if (w_iss_fire) begin
      w_pend_nxt[i_iss_rd] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
    w_cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_pend_nxt[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= '0;
      r_rr_last  <= 1'b0;
      r_rf_wr    <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_data  <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pending  <= w_pend_nxt;
      r_pend_cnt <= w_cnt_nxt;
      r_rf_wr    <= w_grant && (w_gnt_rd != '0);
      if (w_grant) begin
        r_rr_last <= w_gnt_mem;
        r_rf_addr <= w_gnt_rd;
        r_rf_data <= w_gnt_data;
      end
    end
  end

  assign o_iss_ready = w_iss_ready;
  assign o_q_busy1   = r_pending[i_q_addr1];
  assign o_q_busy2   = r_pending[i_q_addr2];
  assign o_alu_ready = w_gnt_alu;
  assign o_mem_ready = w_gnt_mem;
  assign o_rf_wr     = r_rf_wr;
  assign o_rf_addr   = r_rf_addr;
  assign o_rf_data   = r_rf_data;
  assign o_pend_cnt  = r_pend_cnt;

endmodule

`default_nettype wire
